mem_rd_sched: RTL and testbench

//  Work-conserving round-robin scheduler for the single shared packet-memory read port.
//  It sits between the N per-port memory read controllers and the packet memory.
//  It grants one read per cycle and tracks the port ID of every in-flight read in a tag FIFO.
//  In-order memory responses are steered back to the issuing port using those tags.

---
 rtl/mem_pkg.sv | 5 +
 rtl/mem_rd_sched.sv | 102 ++++++++++
 tb/tb_mem_rd_sched.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared packet-memory geometry
package mem_pkg;
    localparam int ADDR_W     = 16;
    localparam int BLOCK_BITS = 32;
endpackage

// File: rtl/mem_rd_sched.sv
// rtl/mem_rd_sched.sv - round-robin scheduler for the shared packet-memory read port
// Grants one read per cycle and steers in-order responses back to the issuing port via a tag FIFO.
module mem_rd_sched #(
    parameter int N          = 4,
    parameter int ADDR_W     = mem_pkg::ADDR_W,
    parameter int BLOCK_BITS = mem_pkg::BLOCK_BITS,
    parameter int MAX_OUTST  = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [N-1:0]                 rd_req_i,
    input  logic [ADDR_W-1:0]            rd_addr_i [N],
    output logic [N-1:0]                 rd_gnt_o,
    output logic [N-1:0]                 rvalid_o,
    output logic [BLOCK_BITS-1:0]        rdata_o,
    output logic                         mem_re_o,
    output logic [ADDR_W-1:0]            mem_raddr_o,
    input  logic                         mem_rvalid_i,
    input  logic [BLOCK_BITS-1:0]        mem_rdata_i,
    output logic [$clog2(MAX_OUTST):0]   outst_o,
    output logic                         err_o
);
    localparam int PW = $clog2(N);
    localparam int CW = $clog2(MAX_OUTST) + 1;
    localparam int TW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

    logic [PW-1:0] rr_ptr;
    logic [PW-1:0] winner;
    logic [PW-1:0] idx;
    logic          found;
    logic          can_issue;
    logic          empty;
    logic          push;
    logic          pop;
    logic [PW-1:0] tags [MAX_OUTST];
    logic [TW-1:0] wr_ptr;
    logic [TW-1:0] rd_ptr;

    function automatic logic [TW-1:0] ptr_inc(input logic [TW-1:0] p);
        return (int'(p) == MAX_OUTST - 1) ? '0 : p + TW'(1);
    endfunction

    // Full check uses the registered count, so a same-cycle pop never frees a slot early.
    assign can_issue = (outst_o != CW'(MAX_OUTST));
    assign empty     = (outst_o == '0);

    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        if (rst_n && can_issue) begin
            for (int i = 0; i < N; i++) begin
                idx = rr_ptr + PW'(i);
                if (!found && rd_req_i[idx]) begin
                    found  = 1'b1;
                    winner = idx;
                end
            end
        end
    end

    assign push        = found;
    assign pop         = rst_n && mem_rvalid_i && !empty;
    assign rd_gnt_o    = found ? (N'(1) << winner) : '0;
    assign mem_re_o    = found;
    assign mem_raddr_o = found ? rd_addr_i[winner] : '0;
    assign rvalid_o    = pop ? (N'(1) << tags[rd_ptr]) : '0;
    assign rdata_o     = rst_n ? mem_rdata_i : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr  <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            outst_o <= '0;
            err_o   <= 1'b0;
        end else begin
            if (push) begin
                rr_ptr <= winner + PW'(1);
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   outst_o <= outst_o + CW'(1);
                2'b01:   outst_o <= outst_o - CW'(1);
                default: outst_o <= outst_o;
            endcase
            if (mem_rvalid_i && empty) begin
                err_o <= 1'b1;
            end
        end
    end

    // Tag storage needs no reset: entries are only read behind a valid count.
    always_ff @(posedge clk) begin
        if (push) begin
            tags[wr_ptr] <= winner;
        end
    end
endmodule

// File: tb/tb_mem_rd_sched.sv
// tb/tb_mem_rd_sched.sv - scoreboard bench for mem_rd_sched
module tb_mem_rd_sched;
    localparam int N    = 4;
    localparam int AW   = 16;
    localparam int BW   = 32;
    localparam int MAXO = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  rd_req_i;
    logic [AW-1:0] rd_addr_i [N];
    logic [N-1:0]  rd_gnt_o;
    logic [N-1:0]  rvalid_o;
    logic [BW-1:0] rdata_o;
    logic          mem_re_o;
    logic [AW-1:0] mem_raddr_o;
    logic          mem_rvalid_i;
    logic [BW-1:0] mem_rdata_i;
    logic [2:0]    outst_o;
    logic          err_o;

    typedef struct {
        int          port;
        logic [31:0] data;
    } ent_t;

    ent_t sb [$];
    int   m_rr;
    bit   m_err;
    int   n_cmp;
    int   n_bad;

    mem_rd_sched #(.N(N), .ADDR_W(AW), .BLOCK_BITS(BW), .MAX_OUTST(MAXO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rd_req_i     (rd_req_i),
        .rd_addr_i    (rd_addr_i),
        .rd_gnt_o     (rd_gnt_o),
        .rvalid_o     (rvalid_o),
        .rdata_o      (rdata_o),
        .mem_re_o     (mem_re_o),
        .mem_raddr_o  (mem_raddr_o),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i),
        .outst_o      (outst_o),
        .err_o        (err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] data_of(input logic [15:0] a);
        return {~a, a};
    endfunction

    // One scheduler cycle: drive at negedge, check combinational outputs, advance the model at posedge.
    task automatic step(input logic [3:0] req, input bit rv);
        int          cnt;
        int          w;
        bit          fnd;
        logic [31:0] exp_gnt;
        logic [31:0] exp_addr;
        ent_t        e;
        cnt          = sb.size();
        rd_req_i     = req;
        mem_rvalid_i = rv;
        mem_rdata_i  = (cnt > 0) ? sb[0].data : 32'hDEAD_BEEF;
        #1;
        fnd = 1'b0;
        w   = 0;
        if (cnt != MAXO) begin
            for (int i = 0; i < N; i++) begin
                int p;
                p = (m_rr + i) % N;
                if (!fnd && req[p]) begin
                    fnd = 1'b1;
                    w   = p;
                end
            end
        end
        exp_gnt  = fnd ? (32'd1 << w) : 32'd0;
        exp_addr = fnd ? 32'(rd_addr_i[w]) : 32'd0;
        chk("gnt", 32'(rd_gnt_o), exp_gnt);
        chk("mem_re", 32'(mem_re_o), 32'(fnd));
        chk("mem_raddr", 32'(mem_raddr_o), exp_addr);
        chk("outst", 32'(outst_o), 32'(cnt));
        chk("err", 32'(err_o), 32'(m_err));
        if (rv && cnt > 0) begin
            e = sb.pop_front();
            chk("rvalid", 32'(rvalid_o), 32'd1 << e.port);
            chk("rdata", rdata_o, e.data);
        end else begin
            chk("rvalid_idle", 32'(rvalid_o), 32'd0);
        end
        @(posedge clk);
        if (rv && cnt == 0) m_err = 1'b1;
        if (fnd) begin
            sb.push_back('{port: w, data: data_of(rd_addr_i[w])});
            m_rr = (w + 1) % N;
        end
        @(negedge clk);
        if (fnd) rd_addr_i[w] = rd_addr_i[w] + 16'd1;
    endtask

    task automatic drain();
        for (int k = 0; k < 8 && sb.size() > 0; k++) step(4'b0000, 1'b1);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        m_rr  = 0;
        m_err = 1'b0;
        for (int p = 0; p < N; p++) rd_addr_i[p] = 16'(p << 12);
        rst_n        = 1'b0;
        rd_req_i     = 4'b1111;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h1234_5678;
        #1;
        chk("rst_gnt", 32'(rd_gnt_o), 32'd0);
        chk("rst_re", 32'(mem_re_o), 32'd0);
        chk("rst_raddr", 32'(mem_raddr_o), 32'd0);
        chk("rst_rvalid", 32'(rvalid_o), 32'd0);
        chk("rst_rdata", rdata_o, 32'd0);
        chk("rst_outst", 32'(outst_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // round robin with all requesting, memory latency 1
        for (int k = 0; k < 8; k++) step(4'b1111, sb.size() > 0);
        drain();

        // rr_ptr to 2, then only ports 0 and 1 request
        step(4'b0010, 1'b0);
        drain();
        step(4'b0011, 1'b0);
        step(4'b0011, 1'b0);
        drain();

        // memory stalls until the tag FIFO is full, then one response
        for (int k = 0; k < 6; k++) step(4'b1111, 1'b0);
        step(4'b1111, 1'b1);
        step(4'b1111, 1'b0);

        // push and pop together at outst=2
        step(4'b0000, 1'b1);
        step(4'b0000, 1'b1);
        step(4'b1111, 1'b1);
        step(4'b0000, 1'b0);
        drain();

        // response with nothing in flight: sticky error
        step(4'b0000, 1'b1);
        step(4'b0000, 1'b0);
        step(4'b0101, 1'b0);
        drain();

        // async reset with three reads in flight
        for (int k = 0; k < 3; k++) step(4'b1111, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_outst", 32'(outst_o), 32'd0);
        chk("arst_gnt", 32'(rd_gnt_o), 32'd0);
        chk("arst_err", 32'(err_o), 32'd0);
        sb.delete();
        m_rr  = 0;
        m_err = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step(4'b1111, 1'b0);
        step(4'b0000, 1'b1);
        step(4'b0000, 1'b1);
        step(4'b0000, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
